unit_attacker: RTL and testbench

- Drives the attacker side of the tower damage interface: produces `damageOut` plus the one-cycle `attackSCEN` strobe consumed by a tower.
- One instance is one deployed unit. It spawns at its owner's side, marches across the 0..511 field on game ticks, and strikes the opposing tower periodically once in range.
- It stops when the target reports dead or when the level is aborted.

---
 rtl/unit_attacker_pkg.sv | 16 +
 rtl/unit_mover.sv | 31 +++
 rtl/unit_attacker.sv | 79 +++++++
 tb/tb_unit_attacker.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/unit_attacker_pkg.sv
// unit_attacker_pkg: shared game state encodings, field limits and helpers for deployed units
package unit_attacker_pkg;
  localparam int DMG_W = 8;
  localparam logic [8:0] FIELD_MIN = 9'd0;
  localparam logic [8:0] FIELD_MAX = 9'd511;
  typedef enum logic [4:0] {
    S_IDLE   = 5'b00001,
    S_DEPLOY = 5'b00010,
    S_MARCH  = 5'b00100,
    S_ATTACK = 5'b01000,
    S_COOL   = 5'b10000
  } state_e;
  function automatic logic [3:0] cool_load(input logic [3:0] c);
    return (c == 4'd0) ? 4'd1 : c;
  endfunction
endpackage

// File: rtl/unit_mover.sv
// unit_mover: position register with saturating march step and target range compare
module unit_mover
  import unit_attacker_pkg::*;
#(
  parameter logic [8:0] SPEED = 9'd4,
  parameter logic [8:0] RANGE = 9'd32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic       step,
  input  logic       player,
  input  logic [8:0] start_pos,
  output logic [8:0] position,
  output logic       in_range
);
  logic [8:0] pos_q, pos_d;
  logic [9:0] up;
  always_comb begin
    up = {1'b0, pos_q} + {1'b0, SPEED};
    pos_d = load ? start_pos :
            !step ? pos_q :
            player ? ((pos_q < SPEED) ? FIELD_MIN : pos_q - SPEED) :
            ((up > {1'b0, FIELD_MAX}) ? FIELD_MAX : up[8:0]);
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) pos_q <= FIELD_MIN;
    else pos_q <= pos_d;
  assign position = pos_q;
  assign in_range = player ? (pos_q <= RANGE) : (pos_q >= FIELD_MAX - RANGE);
endmodule

// File: rtl/unit_attacker.sv
// unit_attacker: one deployed unit that marches toward the opposing tower and strikes it periodically
module unit_attacker
  import unit_attacker_pkg::*;
#(
  parameter logic [DMG_W-1:0] DAMAGE   = 8'd16,
  parameter logic [8:0]       SPEED    = 9'd4,
  parameter logic [8:0]       RANGE    = 9'd32,
  parameter logic [3:0]       COOLDOWN = 4'd8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             gameTick,
  input  logic             player,
  input  logic             deploy,
  input  logic             abort,
  input  logic             targetDead,
  output logic [DMG_W-1:0] damageOut,
  output logic             attackSCEN,
  output logic [8:0]       position,
  output logic             active,
  output logic [7:0]       hitCount
);
  state_e state_q, state_d;
  logic attack_q, attack_d, load, step, in_range;
  logic [DMG_W-1:0] dmg_q, dmg_d;
  logic [7:0] hit_q, hit_d;
  logic [3:0] cnt_q, cnt_d;
  always_ff @(posedge clk or negedge reset)
    if (!reset) state_q <= S_IDLE;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   state_d = deploy ? S_DEPLOY : S_IDLE;
      S_DEPLOY: state_d = S_MARCH;
      S_MARCH:  state_d = targetDead ? S_IDLE : (gameTick && in_range) ? S_ATTACK : S_MARCH;
      S_ATTACK: state_d = targetDead ? S_IDLE : S_COOL;
      S_COOL:   state_d = targetDead ? S_IDLE : (gameTick && cnt_q <= 4'd1) ? S_ATTACK : S_COOL;
      default:  state_d = S_IDLE;
    endcase
    if (abort) state_d = S_IDLE;
  end
  // strike outputs are registered on entry to ATTACK so they line up with that state
  always_comb begin
    load = state_q == S_DEPLOY;
    step = state_q == S_MARCH && gameTick && !in_range && state_d == S_MARCH;
    attack_d = state_d == S_ATTACK;
    dmg_d = attack_d ? DAMAGE : '0;
    hit_d = load ? 8'd0 : (attack_d && hit_q != 8'hFF) ? hit_q + 8'd1 : hit_q;
    cnt_d = attack_d ? cool_load(COOLDOWN) :
            (state_q == S_COOL && gameTick && cnt_q != 4'd0) ? cnt_q - 4'd1 : cnt_q;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      attack_q <= 1'b0;
      dmg_q <= '0;
      hit_q <= 8'd0;
      cnt_q <= 4'd0;
    end else begin
      attack_q <= attack_d;
      dmg_q <= dmg_d;
      hit_q <= hit_d;
      cnt_q <= cnt_d;
    end
  unit_mover #(.SPEED(SPEED), .RANGE(RANGE)) u_mover (
    .clk(clk),
    .reset(reset),
    .load(load),
    .step(step),
    .player(player),
    .start_pos(player ? FIELD_MAX : FIELD_MIN),
    .position(position),
    .in_range(in_range)
  );
  assign attackSCEN = attack_q;
  assign damageOut = dmg_q;
  assign hitCount = hit_q;
  assign active = state_q != S_IDLE;
endmodule

// File: tb/tb_unit_attacker.sv
// tb_unit_attacker: scoreboard bench for march, strike timing, cooldown, abort and reset behaviour
module tb_unit_attacker;
  logic clk = 0, reset = 0, game_tick = 0, player = 0, abort = 0, target_dead = 0;
  logic deploy [3];
  logic scen [3];
  logic act [3];
  logic prev [3] = '{1'b0, 1'b0, 1'b0};
  logic [7:0] dmg [3];
  logic [7:0] hit [3];
  logic [8:0] pos [3];
  int tick_cnt = 0, checks = 0, errors = 0, health = 255;
  typedef struct {int unit; int tick; int hits;} exp_t;
  exp_t sb [$];
  exp_t e;

  always #5 clk = ~clk;

  unit_attacker u0 (.clk(clk), .reset(reset), .gameTick(game_tick), .player(player), .deploy(deploy[0]),
    .abort(abort), .targetDead(target_dead), .damageOut(dmg[0]), .attackSCEN(scen[0]),
    .position(pos[0]), .active(act[0]), .hitCount(hit[0]));
  unit_attacker #(.SPEED(9'd100)) u1 (.clk(clk), .reset(reset), .gameTick(game_tick), .player(player),
    .deploy(deploy[1]), .abort(abort), .targetDead(target_dead), .damageOut(dmg[1]), .attackSCEN(scen[1]),
    .position(pos[1]), .active(act[1]), .hitCount(hit[1]));
  unit_attacker #(.COOLDOWN(4'd0)) u2 (.clk(clk), .reset(reset), .gameTick(game_tick), .player(player),
    .deploy(deploy[2]), .abort(abort), .targetDead(target_dead), .damageOut(dmg[2]), .attackSCEN(scen[2]),
    .position(pos[2]), .active(act[2]), .hitCount(hit[2]));

  initial forever begin
    repeat (3) @(posedge clk);
    #1 game_tick = 1;
    @(posedge clk);
    #1 game_tick = 0;
  end

  always @(posedge clk) if (game_tick) tick_cnt <= tick_cnt + 1;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic push_exp(input int u, input int t, input int h);
    exp_t x;
    x.unit = u;
    x.tick = t;
    x.hits = h;
    sb.push_back(x);
  endtask

  task automatic wait_tick(input int target);
    int n = 0;
    while (tick_cnt < target && n < 4000) begin
      @(negedge clk);
      n++;
    end
    if (tick_cnt < target) check("tick_timeout", tick_cnt, target);
  endtask

  task automatic deploy_unit(input int u, output int b);
    deploy[u] = 1;
    @(negedge clk);
    deploy[u] = 0;
    @(negedge clk);
    b = tick_cnt;
  endtask

  task automatic pulse_abort();
    abort = 1;
    @(negedge clk);
    abort = 0;
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      check("scen_pulse", int'(prev[i] & scen[i]), 0);
      if (!scen[i]) check("dmg_idle", dmg[i], 0);
      else if (sb.size() == 0) check("sb_strike_expected", sb.size(), 1);
      else begin
        e = sb.pop_front();
        check("strike_unit", i, e.unit);
        check("strike_tick", tick_cnt, e.tick);
        check("strike_dmg", dmg[i], 16);
        check("strike_hits", hit[i], e.hits);
        if (i == 0) health = (health > int'(dmg[i])) ? health - int'(dmg[i]) : 0;
      end
      prev[i] = scen[i];
    end
  end

  initial begin
    int base;
    for (int i = 0; i < 3; i++) deploy[i] = 0;
    repeat (2) @(negedge clk);
    check("rst_pos", pos[0], 0);
    check("rst_active", act[0], 0);
    check("rst_hit", hit[0], 0);
    check("rst_scen", scen[0], 0);
    check("rst_dmg", dmg[0], 0);
    reset = 1;
    @(negedge clk);
    player = 1;
    deploy_unit(0, base);
    check("p_deploy_pos", pos[0], 511);
    for (int k = 0; k < 16; k++) push_exp(0, base + 121 + 8 * k, k + 1);
    wait_tick(base + 120);
    check("p_pos120", pos[0], 31);
    wait_tick(base + 123);
    check("p_hit1", hit[0], 1);
    check("p_pos_frozen", pos[0], 31);
    wait_tick(base + 243);
    check("p_hit16", hit[0], 16);
    check("p_health", health, 0);
    target_dead = 1;
    @(negedge clk);
    target_dead = 0;
    check("dead_active", act[0], 0);
    check("dead_hit_hold", hit[0], 16);
    wait_tick(base + 260);
    check("dead_sb_empty", sb.size(), 0);
    check("dead_hit_hold2", hit[0], 16);
    player = 0;
    deploy_unit(0, base);
    check("e_deploy_pos", pos[0], 0);
    check("e_hit_clear", hit[0], 0);
    push_exp(0, base + 121, 1);
    wait_tick(base + 120);
    check("e_pos120", pos[0], 480);
    wait_tick(base + 121);
    pulse_abort();
    check("e_abort_active", act[0], 0);
    check("e_hit", hit[0], 1);
    wait_tick(base + 140);
    check("e_sb_empty", sb.size(), 0);
    check("e_pos_hold", pos[0], 480);
    deploy_unit(0, base);
    wait_tick(base + 10);
    check("m_pos10", pos[0], 40);
    deploy[0] = 1;
    @(negedge clk);
    deploy[0] = 0;
    wait_tick(base + 11);
    check("m_pos11", pos[0], 44);
    check("m_active", act[0], 1);
    wait_tick(base + 75);
    check("m_pos300", pos[0], 300);
    #2 reset = 0;
    #1;
    check("ar_pos", pos[0], 0);
    check("ar_active", act[0], 0);
    check("ar_scen", scen[0], 0);
    check("ar_dmg", dmg[0], 0);
    check("ar_hit", hit[0], 0);
    @(negedge clk);
    reset = 1;
    player = 1;
    @(negedge clk);
    deploy_unit(0, base);
    check("ar_redeploy_pos", pos[0], 511);
    check("ar_redeploy_active", act[0], 1);
    pulse_abort();
    check("ar_abort_active", act[0], 0);
    deploy_unit(1, base);
    push_exp(1, base + 6, 1);
    for (int k = 1; k <= 5; k++) begin
      wait_tick(base + k);
      check("s100_pos", pos[1], 511 - 100 * k);
    end
    wait_tick(base + 6);
    check("s100_no_underflow", pos[1], 11);
    pulse_abort();
    check("s100_abort_active", act[1], 0);
    check("s100_sb_empty", sb.size(), 0);
    player = 0;
    deploy_unit(2, base);
    for (int k = 0; k < 4; k++) push_exp(2, base + 121 + k, k + 1);
    wait_tick(base + 124);
    pulse_abort();
    check("c0_abort_active", act[2], 0);
    check("c0_hit", hit[2], 4);
    wait_tick(base + 130);
    check("c0_sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
